// File: rtl/ifetch_queue.sv
// Purpose: fetch front-end; owns the fetch PC, issues in-order word reads and queues returned words + PCs.
// Latency: imem response -> ins_valid 1 cycle (0 cycles when IFQ_BYPASS_EN and the FIFO is empty).
// Backpressure: ins_ready low fills the FIFO; requests stop once queued + in-flight words reach DEPTH.
//
// Optional feature macro: IFQ_BYPASS_EN
//   defined   - a response arriving with an empty FIFO, nothing to drop and no redirect is presented
//               to the decoder in the same cycle (combinational memory->decoder path); it is written
//               into the FIFO only if the decoder does not take it that cycle.
//   undefined - every response goes through the FIFO; ins_* come from registers only.
//
// Ports:
//   clk, rst_n                        clock (rising edge) and asynchronous active-low reset
//   imem_req_valid/ready/addr         word fetch request toward instruction memory
//   imem_rsp_valid/data               in-order read data, at least one cycle after the accept
//   redirect_valid/pc                 one-cycle control-flow change; flushes queued and in-flight words
//   ins_valid/ready/data/pc           instruction word and its address toward the decoder
module ifetch_queue #(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              ins_valid,
   input  logic              ins_ready,
   output logic [31:0]       ins_data,
   output logic [ADDR_W-1:0] ins_pc
);

   localparam int          PW      = $clog2(DEPTH);
   localparam int          CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       dat;
   } ent_t;

   // fetch state
   logic [ADDR_W-1:0] fetch_pc;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     drop;

   // PC shadow: one entry per accepted request, consumed in order by responses (dropped ones too)
   logic [ADDR_W-1:0] sh_pc [DEPTH];
   logic [PW-1:0]     sh_wr;
   logic [PW-1:0]     sh_rd;

   // prefetch FIFO
   ent_t              fifo_q [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   logic              fifo_empty;
   logic [CW:0]       credit_used;
   logic              req_fire;
   logic              rsp_take;
   logic              push;
   logic              pop;
   logic [CW-1:0]     inflight_nxt;

   // the low address bits of a redirect target are discarded by design
   logic              unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign fifo_empty  = (count == '0);
   assign credit_used = {1'b0, count} + {1'b0, inflight};

   // Credits cover queued and in-flight words, so every response is guaranteed a FIFO slot.
   // rst_n is folded in so the request stays low for the whole reset, not just after the first edge.
   assign imem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_W);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response is a live instruction only when no stale words remain and no redirect kills it.
   assign rsp_take     = imem_rsp_valid && (drop == '0) && !redirect_valid;
   assign inflight_nxt = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
   assign pop          = !fifo_empty && ins_ready;

`ifdef IFQ_BYPASS_EN
   logic bypass;
   assign bypass    = rst_n && fifo_empty && rsp_take;
   assign ins_valid = !fifo_empty || bypass;
   assign ins_data  = bypass ? imem_rsp_data : fifo_q[rd_ptr].dat;
   assign ins_pc    = bypass ? sh_pc[sh_rd]  : fifo_q[rd_ptr].pc;
   // a bypassed word taken by the decoder this cycle never occupies a slot
   assign push      = rsp_take && !(bypass && ins_ready);
`else
   assign ins_valid = !fifo_empty;
   assign ins_data  = fifo_q[rd_ptr].dat;
   assign ins_pc    = fifo_q[rd_ptr].pc;
   assign push      = rsp_take;
`endif

   // fetch PC, in-flight/drop accounting and PC shadow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
         sh_wr    <= '0;
         sh_rd    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            sh_pc[i] <= '0;
         end
      end else begin
         inflight <= inflight_nxt;
         if (req_fire) begin
            sh_pc[sh_wr] <= fetch_pc;
            sh_wr        <= sh_wr + PW'(1);
         end
         if (imem_rsp_valid) begin
            sh_rd <= sh_rd + PW'(1);
         end
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            // every word still owed by memory belongs to the old path, including any
            // outstanding drops from an earlier redirect
            drop     <= inflight_nxt;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (imem_rsp_valid && (drop != '0)) begin
               drop <= drop - CW'(1);
            end
         end
      end
   end

   // prefetch FIFO; a redirect empties it (a same-cycle pop has already been handed to the decoder)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else if (redirect_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= {sh_pc[sh_rd], imem_rsp_data};
            wr_ptr         <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // memory protocol: responses only for accepted requests, and never into a full FIFO
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (count == DEPTH_W[CW-1:0])));
   a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_rsp_valid && (inflight == '0)));

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
   localparam int RSP2INS = 0;
`else
   localparam int RSP2INS = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        ins_valid;
   logic        ins_ready = 1'b0;
   logic [31:0] ins_data;
   logic [31:0] ins_pc;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ifetch_queue dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ins_valid      (ins_valid),
      .ins_ready      (ins_ready),
      .ins_data       (ins_data),
      .ins_pc         (ins_pc)
   );

   // instruction memory contents: word at address a is 0xC0000000 | (a >> 2)
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC000_0000 | {2'b00, a[31:2]};
   endfunction

   // in-order memory with fixed latency mem_lat: accepted at edge e, data valid after edge e+mem_lat-1
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   mreq_t mq[$];
   int    mcyc = 0;
   int    mem_lat = 1;

   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end else begin
         mcyc++;
         if (imem_rsp_valid && (mq.size() > 0)) void'(mq.pop_front());
         if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, mcyc + mem_lat});
         #1;
         if ((mq.size() > 0) && (mq[0].due <= mcyc + 1)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   // record delivered instructions and accepted requests
   typedef struct { logic [31:0] pc; logic [31:0] dat; int cyc; } ins_t;
   ins_t got[$];
   int   tcyc = 0;
   int   acc_cnt = 0;
   int   t0 = 0;

   always @(posedge clk) begin
      tcyc++;
      if (rst_n && ins_valid && ins_ready) got.push_back('{ins_pc, ins_data, tcyc});
      if (rst_n && imem_req_valid && imem_req_ready) acc_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int lat, input logic rdy, input logic req_rdy);
      rst_n          = 1'b0;
      mem_lat        = lat;
      ins_ready      = rdy;
      imem_req_ready = req_rdy;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      got.delete();
      acc_cnt = 0;
      t0 = tcyc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_chk++; if (ins_valid !== 1'b0) $display("FAIL rst_ins_valid got %b exp 0", ins_valid); else n_pass++;
      n_chk++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); else n_pass++;
      n_chk++; if (ins_data !== 32'h0) $display("FAIL rst_ins_data got %h exp 0", ins_data); else n_pass++;
      n_chk++; if (ins_pc !== 32'h0) $display("FAIL rst_ins_pc got %h exp 0", ins_pc); else n_pass++;
   endtask

   task automatic test_stream();
      do_reset(1, 1'b1, 1'b1);
      repeat (12) tick();
      n_chk++; if (got.size() < 8) $display("FAIL stream_count got %0d exp >=8", got.size()); else n_pass++;
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         n_chk++; if (got[i].pc !== 32'(4 * i)) $display("FAIL stream_pc[%0d] got %h exp %h", i, got[i].pc, 32'(4 * i)); else n_pass++;
         n_chk++; if (got[i].dat !== 32'hC000_0000 + 32'(i)) $display("FAIL stream_dat[%0d] got %h exp %h", i, got[i].dat, 32'hC000_0000 + 32'(i)); else n_pass++;
         n_chk++; if (got[i].cyc != t0 + 2 + RSP2INS + i) $display("FAIL stream_cyc[%0d] got %0d exp %0d", i, got[i].cyc - t0, 2 + RSP2INS + i); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      do_reset(1, 1'b0, 1'b1);
      repeat (20) tick();
      @(negedge clk);
      n_chk++; if (acc_cnt != 4) $display("FAIL bp_accepts got %0d exp 4", acc_cnt); else n_pass++;
      n_chk++; if (imem_req_valid !== 1'b0) $display("FAIL bp_req_valid got %b exp 0", imem_req_valid); else n_pass++;
      n_chk++; if (ins_valid !== 1'b1) $display("FAIL bp_ins_valid got %b exp 1", ins_valid); else n_pass++;
      n_chk++; if (ins_pc !== 32'h0) $display("FAIL bp_head_pc got %h exp 0", ins_pc); else n_pass++;
      ins_ready = 1'b1;
      repeat (12) tick();
      n_chk++; if (got.size() < 8) $display("FAIL bp_count got %0d exp >=8", got.size()); else n_pass++;
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         n_chk++; if (got[i].pc !== 32'(4 * i)) $display("FAIL bp_pc[%0d] got %h exp %h", i, got[i].pc, 32'(4 * i)); else n_pass++;
         n_chk++; if (got[i].dat !== 32'hC000_0000 + 32'(i)) $display("FAIL bp_dat[%0d] got %h exp %h", i, got[i].dat, 32'hC000_0000 + 32'(i)); else n_pass++;
      end
   endtask

   task automatic test_redirect_drop();
      do_reset(3, 1'b1, 1'b0);
      tick();
      imem_req_ready = 1'b1;
      tick();
      tick();
      // two requests (0x0, 0x4) in flight, neither has returned yet
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      @(negedge clk);
      n_chk++; if (imem_req_valid !== 1'b0) $display("FAIL rd_req_in_redirect got %b exp 0", imem_req_valid); else n_pass++;
      tick();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (ins_valid !== 1'b0) $display("FAIL rd_ins_valid_after got %b exp 0", ins_valid); else n_pass++;
      n_chk++; if (imem_req_addr !== 32'h100) $display("FAIL rd_req_addr got %h exp 100", imem_req_addr); else n_pass++;
      tick();
      @(negedge clk);
      n_chk++; if (ins_valid !== 1'b0) $display("FAIL rd_ins_valid_drop got %b exp 0", ins_valid); else n_pass++;
      repeat (8) tick();
      n_chk++; if (got.size() < 2) $display("FAIL rd_count got %0d exp >=2", got.size()); else n_pass++;
      if (got.size() >= 2) begin
         n_chk++; if (got[0].pc !== 32'h100) $display("FAIL rd_pc0 got %h exp 100", got[0].pc); else n_pass++;
         n_chk++; if (got[0].dat !== 32'hC000_0040) $display("FAIL rd_dat0 got %h exp c0000040", got[0].dat); else n_pass++;
         n_chk++; if (got[1].pc !== 32'h104) $display("FAIL rd_pc1 got %h exp 104", got[1].pc); else n_pass++;
      end
   endtask

   task automatic test_req_stall();
      do_reset(1, 1'b1, 1'b1);
      repeat (3) tick();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_chk++; if (imem_req_addr !== 32'hC) $display("FAIL stall_addr[%0d] got %h exp c", i, imem_req_addr); else n_pass++;
         n_chk++; if (imem_req_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b exp 1", i, imem_req_valid); else n_pass++;
         tick();
      end
      imem_req_ready = 1'b1;
      repeat (10) tick();
      n_chk++; if (got.size() < 6) $display("FAIL stall_count got %0d exp >=6", got.size()); else n_pass++;
      for (int i = 0; i < 6 && i < got.size(); i++) begin
         n_chk++; if (got[i].pc !== 32'(4 * i)) $display("FAIL stall_pc[%0d] got %h exp %h", i, got[i].pc, 32'(4 * i)); else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      do_reset(3, 1'b0, 1'b1);
      repeat (5) tick();
      // two words queued (0x0, 0x4), two still in flight (0x8, 0xC)
      @(negedge clk);
      n_chk++; if (ins_valid !== 1'b1) $display("FAIL ar_pre_valid got %b exp 1", ins_valid); else n_pass++;
      n_chk++; if (ins_data !== 32'hC000_0000) $display("FAIL ar_pre_data got %h exp c0000000", ins_data); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++; if (ins_valid !== 1'b0) $display("FAIL ar_ins_valid got %b exp 0", ins_valid); else n_pass++;
      n_chk++; if (imem_req_valid !== 1'b0) $display("FAIL ar_req_valid got %b exp 0", imem_req_valid); else n_pass++;
      n_chk++; if (ins_data !== 32'h0) $display("FAIL ar_ins_data got %h exp 0", ins_data); else n_pass++;
      do_reset(1, 1'b1, 1'b1);
      repeat (6) tick();
      n_chk++; if (got.size() < 2) $display("FAIL ar_count got %0d exp >=2", got.size()); else n_pass++;
      if (got.size() >= 2) begin
         n_chk++; if (got[0].pc !== 32'h0) $display("FAIL ar_pc0 got %h exp 0", got[0].pc); else n_pass++;
         n_chk++; if (got[1].pc !== 32'h4) $display("FAIL ar_pc1 got %h exp 4", got[1].pc); else n_pass++;
      end
   endtask

   task automatic test_latency();
      logic exp_v;
      exp_v = (RSP2INS == 0);
      do_reset(1, 1'b0, 1'b1);
      tick();
      // first response is on the bus in this cycle
      @(negedge clk);
      n_chk++; if (ins_valid !== exp_v) $display("FAIL lat_same_cycle got %b exp %b", ins_valid, exp_v); else n_pass++;
      tick();
      @(negedge clk);
      n_chk++; if (ins_valid !== 1'b1) $display("FAIL lat_next_cycle got %b exp 1", ins_valid); else n_pass++;
      n_chk++; if (ins_pc !== 32'h0) $display("FAIL lat_pc got %h exp 0", ins_pc); else n_pass++;
      n_chk++; if (ins_data !== 32'hC000_0000) $display("FAIL lat_data got %h exp c0000000", ins_data); else n_pass++;
   endtask

   task automatic test_redirect_full();
      do_reset(1, 1'b0, 1'b1);
      repeat (20) tick();
      // FIFO full; the decoder takes the head in the redirect cycle
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      ins_ready      = 1'b1;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      n_chk++; if (ins_valid !== 1'b0) $display("FAIL rf_ins_valid got %b exp 0", ins_valid); else n_pass++;
      repeat (6) tick();
      n_chk++; if (got.size() < 2) $display("FAIL rf_count got %0d exp >=2", got.size()); else n_pass++;
      if (got.size() >= 2) begin
         n_chk++; if (got[0].pc !== 32'h0) $display("FAIL rf_pc0 got %h exp 0", got[0].pc); else n_pass++;
         n_chk++; if (got[1].pc !== 32'h200) $display("FAIL rf_pc1 got %h exp 200", got[1].pc); else n_pass++;
         n_chk++; if (got[1].dat !== 32'hC000_0080) $display("FAIL rf_dat1 got %h exp c0000080", got[1].dat); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drop();
      test_req_stall();
      test_async_reset();
      test_latency();
      test_redirect_full();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
